// File: rtl/dag_index_seq.sv
// Index-register sequencer for one data address generator: four I/M/L register sets,
// address issue with optional bit reversal, index write-back from the modulo unit, wrap tracking.
module dag_index_seq #(
    parameter int AW      = 14,
    parameter bit BREV_EN = 1'b1,
    parameter int WCNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              gen_req,
    input  logic [1:0]        gen_isel,
    input  logic [1:0]        gen_msel,
    input  logic              brev,
    output logic [AW-1:0]     addr_out,
    output logic              addr_vld,
    output logic [AW-1:0]     mod_I,
    output logic [AW-1:0]     mod_M,
    output logic [AW-1:0]     mod_L,
    input  logic [AW-1:0]     mod_newI,
    input  logic              mod_wrap,
    input  logic              wr_en,
    input  logic [1:0]        wr_grp,
    input  logic [1:0]        wr_sel,
    input  logic [AW-1:0]     wr_data,
    input  logic              rd_en,
    input  logic [1:0]        rd_grp,
    input  logic [1:0]        rd_sel,
    output logic [AW-1:0]     rd_data,
    output logic              rd_vld,
    input  logic              wrap_clr,
    output logic              wrap_sticky,
    output logic [WCNT_W-1:0] wrap_cnt
);

    logic [AW-1:0] i_reg [4];
    logic [AW-1:0] m_reg [4];
    logic [AW-1:0] l_reg [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_set
            logic [AW-1:0] i_q;
            logic [AW-1:0] m_q;
            logic [AW-1:0] l_q;
            logic          i_wr;
            logic          i_mod;
            logic          m_wr;
            logic          l_wr;

            assign i_wr  = wr_en && (wr_grp == 2'd0) && (wr_sel == 2'(gi));
            assign m_wr  = wr_en && (wr_grp == 2'd1) && (wr_sel == 2'(gi));
            assign l_wr  = wr_en && (wr_grp == 2'd2) && (wr_sel == 2'(gi));
            assign i_mod = gen_req && (gen_isel == 2'(gi));

            // An explicit write to I beats the post-modify write-back.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    i_q <= '0;
                    m_q <= '0;
                    l_q <= '0;
                end else begin
                    if (i_wr)
                        i_q <= wr_data;
                    else if (i_mod)
                        i_q <= mod_newI;
                    if (m_wr)
                        m_q <= wr_data;
                    if (l_wr)
                        l_q <= wr_data;
                end
            end

            assign i_reg[gi] = i_q;
            assign m_reg[gi] = m_q;
            assign l_reg[gi] = l_q;
        end
    endgenerate

    assign mod_I = i_reg[gen_isel];
    assign mod_M = m_reg[gen_msel];
    assign mod_L = l_reg[gen_isel];

    logic [AW-1:0] i_rev;
    logic [AW-1:0] addr_next;

    generate
        for (gi = 0; gi < AW; gi++) begin : g_rev
            assign i_rev[gi] = mod_I[AW-1-gi];
        end
    endgenerate

    assign addr_next = (BREV_EN && brev) ? i_rev : mod_I;

    logic [AW-1:0] rd_next;

    always_comb begin
        rd_next = '0;
        case (rd_grp)
            2'd0:    rd_next = i_reg[rd_sel];
            2'd1:    rd_next = m_reg[rd_sel];
            2'd2:    rd_next = l_reg[rd_sel];
            default: rd_next = '0;
        endcase
    end

    logic wrap_hit;
    assign wrap_hit = gen_req && mod_wrap;

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_out    <= '0;
            addr_vld    <= 1'b0;
            rd_data     <= '0;
            rd_vld      <= 1'b0;
            wrap_sticky <= 1'b0;
            wrap_cnt    <= '0;
        end else begin
            addr_vld <= gen_req;
            if (gen_req)
                addr_out <= addr_next;
            rd_vld <= rd_en;
            if (rd_en)
                rd_data <= rd_next;
            // A wrap arriving with a clear restarts the count at one.
            if (wrap_clr) begin
                wrap_sticky <= wrap_hit;
                wrap_cnt    <= wrap_hit ? WCNT_W'(1) : '0;
            end else if (wrap_hit) begin
                wrap_sticky <= 1'b1;
                if (wrap_cnt != '1)
                    wrap_cnt <= wrap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dag_index_seq.sv
// Self-checking bench for dag_index_seq: directed test-plan scenarios plus randomized
// traffic checked against a rule-level register-file model.
module tb_dag_index_seq;
    localparam int AW = 14;
    localparam int WCNT_W = 8;

    logic              CLK;
    logic              RST;
    logic              gen_req;
    logic [1:0]        gen_isel;
    logic [1:0]        gen_msel;
    logic              brev;
    logic [AW-1:0]     addr_out;
    logic              addr_vld;
    logic [AW-1:0]     mod_I;
    logic [AW-1:0]     mod_M;
    logic [AW-1:0]     mod_L;
    logic [AW-1:0]     mod_newI;
    logic              mod_wrap;
    logic              wr_en;
    logic [1:0]        wr_grp;
    logic [1:0]        wr_sel;
    logic [AW-1:0]     wr_data;
    logic              rd_en;
    logic [1:0]        rd_grp;
    logic [1:0]        rd_sel;
    logic [AW-1:0]     rd_data;
    logic              rd_vld;
    logic              wrap_clr;
    logic              wrap_sticky;
    logic [WCNT_W-1:0] wrap_cnt;

    dag_index_seq #(.AW(AW), .BREV_EN(1'b1), .WCNT_W(WCNT_W)) dut (
        .CLK(CLK), .RST(RST), .gen_req(gen_req), .gen_isel(gen_isel), .gen_msel(gen_msel),
        .brev(brev), .addr_out(addr_out), .addr_vld(addr_vld), .mod_I(mod_I), .mod_M(mod_M),
        .mod_L(mod_L), .mod_newI(mod_newI), .mod_wrap(mod_wrap), .wr_en(wr_en), .wr_grp(wr_grp),
        .wr_sel(wr_sel), .wr_data(wr_data), .rd_en(rd_en), .rd_grp(rd_grp), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_vld(rd_vld), .wrap_clr(wrap_clr), .wrap_sticky(wrap_sticky),
        .wrap_cnt(wrap_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [AW-1:0] m_i [4];
    logic [AW-1:0] m_m [4];
    logic [AW-1:0] m_l [4];
    logic [AW-1:0] e_addr;
    logic          e_vld;
    logic [AW-1:0] e_rd;
    logic          e_rvld;
    logic          e_sticky;
    int            e_cnt;

    task automatic idle();
        RST = 0; gen_req = 0; gen_isel = 0; gen_msel = 0; brev = 0;
        mod_newI = 0; mod_wrap = 0; wr_en = 0; wr_grp = 0; wr_sel = 0; wr_data = 0;
        rd_en = 0; rd_grp = 0; rd_sel = 0; wrap_clr = 0;
    endtask

    // Apply the behavioural rules to the model for the current inputs, then advance one edge.
    task automatic step();
        logic [AW-1:0] a;
        logic [AW-1:0] r;
        logic hit;
        if (RST) begin
            for (int k = 0; k < 4; k++) begin m_i[k] = 0; m_m[k] = 0; m_l[k] = 0; end
            e_addr = 0; e_vld = 0; e_rd = 0; e_rvld = 0; e_sticky = 0; e_cnt = 0;
        end else begin
            e_rvld = rd_en;
            if (rd_en) begin
                if (rd_grp == 0) e_rd = m_i[rd_sel];
                else if (rd_grp == 1) e_rd = m_m[rd_sel];
                else if (rd_grp == 2) e_rd = m_l[rd_sel];
                else e_rd = 0;
            end
            e_vld = gen_req;
            if (gen_req) begin
                a = m_i[gen_isel];
                r = a;
                if (brev) for (int k = 0; k < AW; k++) r[AW-1-k] = a[k];
                e_addr = r;
                m_i[gen_isel] = mod_newI;
            end
            hit = gen_req && mod_wrap;
            if (wrap_clr) begin
                e_sticky = hit;
                e_cnt = hit ? 1 : 0;
            end else if (hit) begin
                e_sticky = 1;
                e_cnt = (e_cnt >= 255) ? 255 : e_cnt + 1;
            end
            if (wr_en) begin
                if (wr_grp == 0) m_i[wr_sel] = wr_data;
                else if (wr_grp == 1) m_m[wr_sel] = wr_data;
                else if (wr_grp == 2) m_l[wr_sel] = wr_data;
            end
        end
        @(posedge CLK);
        #1;
        $display("txn rst=%0b req=%0b isel=%0d wr=%0b/%0d/%0d rd=%0b addr=%h vld=%0b rd_data=%h cnt=%0d",
                 RST, gen_req, gen_isel, wr_en, wr_grp, wr_sel, rd_en, addr_out, addr_vld, rd_data, wrap_cnt);
    endtask

    task automatic wr(input logic [1:0] g, input logic [1:0] s, input logic [AW-1:0] d);
        idle(); wr_en = 1; wr_grp = g; wr_sel = s; wr_data = d; step(); idle();
    endtask

    task automatic rd(input logic [1:0] g, input logic [1:0] s);
        idle(); rd_en = 1; rd_grp = g; rd_sel = s; step(); idle();
    endtask

    task automatic test_reset();
        idle(); RST = 1; step(); step(); idle();
        total++; if (addr_out !== 14'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", addr_out); end
        total++; if (addr_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", addr_vld); end
        total++; if (rd_data !== 14'h0 || rd_vld !== 1'b0) begin bad++; $display("FAIL rst_rd got=%h/%b exp=0/0", rd_data, rd_vld); end
        total++; if (wrap_sticky !== 1'b0 || wrap_cnt !== 8'd0) begin bad++; $display("FAIL rst_wrap got=%b/%0d exp=0/0", wrap_sticky, wrap_cnt); end
        for (int k = 0; k < 4; k++) begin
            gen_isel = 2'(k); gen_msel = 2'(k); #1;
            total++; if (mod_I !== 0 || mod_M !== 0 || mod_L !== 0) begin bad++; $display("FAIL rst_regs%0d got=%h/%h/%h exp=0", k, mod_I, mod_M, mod_L); end
        end
        idle();
    endtask

    task automatic test_modulo_wrap();
        wr(2, 0, 14'd10); wr(0, 0, 14'd8); wr(1, 0, 14'd3);
        gen_req = 1; gen_isel = 0; gen_msel = 0; mod_newI = 14'd1; mod_wrap = 1; #1;
        total++; if (mod_I !== 14'd8 || mod_M !== 14'd3 || mod_L !== 14'd10) begin bad++; $display("FAIL mw_modio got=%h/%h/%h exp=8/3/a", mod_I, mod_M, mod_L); end
        step(); idle();
        total++; if (addr_out !== 14'd8 || addr_vld !== 1'b1) begin bad++; $display("FAIL mw_addr got=%h/%b exp=0008/1", addr_out, addr_vld); end
        total++; if (wrap_sticky !== 1'b1 || wrap_cnt !== 8'd1) begin bad++; $display("FAIL mw_wrap got=%b/%0d exp=1/1", wrap_sticky, wrap_cnt); end
        rd(0, 0);
        total++; if (rd_data !== 14'd1 || rd_vld !== 1'b1) begin bad++; $display("FAIL mw_newI got=%h/%b exp=0001/1", rd_data, rd_vld); end
        total++; if (addr_vld !== 1'b0 || addr_out !== 14'd8) begin bad++; $display("FAIL mw_hold got=%h/%b exp=0008/0", addr_out, addr_vld); end
    endtask

    task automatic test_linear();
        wr(2, 1, 14'd0); wr(0, 1, 14'h3FFE); wr(1, 1, 14'd3);
        gen_req = 1; gen_isel = 1; gen_msel = 1; mod_newI = 14'h0001; mod_wrap = 0; step(); idle();
        total++; if (addr_out !== 14'h3FFE) begin bad++; $display("FAIL lin_addr got=%h exp=3ffe", addr_out); end
        total++; if (wrap_cnt !== 8'd1) begin bad++; $display("FAIL lin_cnt got=%0d exp=1", wrap_cnt); end
        rd(0, 1);
        total++; if (rd_data !== 14'h0001) begin bad++; $display("FAIL lin_newI got=%h exp=0001", rd_data); end
    endtask

    task automatic test_back_to_back();
        wr(2, 2, 14'd10); wr(0, 2, 14'd16); wr(1, 2, 14'h3FFD);
        gen_req = 1; gen_isel = 2; gen_msel = 2; mod_newI = 14'd23; mod_wrap = 1; step();
        total++; if (addr_out !== 14'd16 || addr_vld !== 1'b1) begin bad++; $display("FAIL b2b_addr0 got=%h/%b exp=0010/1", addr_out, addr_vld); end
        total++; if (mod_I !== 14'd23 || mod_M !== 14'h3FFD) begin bad++; $display("FAIL b2b_fwd got=%h/%h exp=0017/3ffd", mod_I, mod_M); end
        mod_newI = 14'd20; mod_wrap = 0; step(); idle();
        total++; if (addr_out !== 14'd23 || addr_vld !== 1'b1) begin bad++; $display("FAIL b2b_addr1 got=%h/%b exp=0017/1", addr_out, addr_vld); end
        total++; if (wrap_cnt !== 8'd2) begin bad++; $display("FAIL b2b_cnt got=%0d exp=2", wrap_cnt); end
        rd(0, 2);
        total++; if (rd_data !== 14'd20) begin bad++; $display("FAIL b2b_newI got=%h exp=0014", rd_data); end
    endtask

    task automatic test_collision();
        wr(0, 3, 14'd5); wr(1, 3, 14'd1); wr(2, 3, 14'd0);
        gen_req = 1; gen_isel = 3; gen_msel = 3; mod_newI = 14'd6; mod_wrap = 1;
        wr_en = 1; wr_grp = 0; wr_sel = 3; wr_data = 14'h0100;
        rd_en = 1; rd_grp = 0; rd_sel = 3;
        wr_en = 1; step(); idle();
        total++; if (addr_out !== 14'd5) begin bad++; $display("FAIL col_addr got=%h exp=0005", addr_out); end
        total++; if (rd_data !== 14'd5 || rd_vld !== 1'b1) begin bad++; $display("FAIL col_rd got=%h/%b exp=0005/1", rd_data, rd_vld); end
        total++; if (wrap_cnt !== 8'd3) begin bad++; $display("FAIL col_cnt got=%0d exp=3", wrap_cnt); end
        rd(0, 3);
        total++; if (rd_data !== 14'h0100) begin bad++; $display("FAIL col_I3 got=%h exp=0100", rd_data); end
        // M/L write alongside a request that uses them: request sees old values
        gen_req = 1; gen_isel = 3; gen_msel = 3; mod_newI = 14'h0100;
        wr_en = 1; wr_grp = 1; wr_sel = 3; wr_data = 14'h0055; #1;
        total++; if (mod_M !== 14'd1) begin bad++; $display("FAIL col_oldM got=%h exp=0001", mod_M); end
        step(); idle();
        rd(3, 0);
        total++; if (rd_data !== 14'd0 || rd_vld !== 1'b1) begin bad++; $display("FAIL rsvd_rd got=%h/%b exp=0000/1", rd_data, rd_vld); end
    endtask

    task automatic test_brev();
        wr(0, 0, 14'h0001); wr(1, 0, 14'd0); wr(2, 0, 14'd0);
        gen_req = 1; gen_isel = 0; gen_msel = 0; brev = 1; mod_newI = 14'h0001; step(); idle();
        total++; if (addr_out !== 14'h2000) begin bad++; $display("FAIL brev_addr got=%h exp=2000", addr_out); end
        rd(0, 0);
        total++; if (rd_data !== 14'h0001) begin bad++; $display("FAIL brev_I0 got=%h exp=0001", rd_data); end
    endtask

    task automatic test_saturation();
        idle(); wrap_clr = 1; step(); idle();
        for (int n = 0; n < 300; n++) begin
            gen_req = 1; gen_isel = 2'(n); mod_newI = 14'(n); mod_wrap = 1; step();
        end
        idle();
        total++; if (wrap_cnt !== 8'd255 || wrap_sticky !== 1'b1) begin bad++; $display("FAIL sat_cnt got=%0d/%b exp=255/1", wrap_cnt, wrap_sticky); end
        gen_req = 1; mod_wrap = 1; wrap_clr = 1; step(); idle();
        total++; if (wrap_cnt !== 8'd1 || wrap_sticky !== 1'b1) begin bad++; $display("FAIL clr_set got=%0d/%b exp=1/1", wrap_cnt, wrap_sticky); end
        wrap_clr = 1; mod_wrap = 1; step(); idle();
        total++; if (wrap_cnt !== 8'd0 || wrap_sticky !== 1'b0) begin bad++; $display("FAIL clr_only got=%0d/%b exp=0/0", wrap_cnt, wrap_sticky); end
        wr(0, 1, 14'h1234); wr(1, 1, 14'h0777); wr(2, 1, 14'h0099);
        gen_req = 1; gen_isel = 1; mod_newI = 14'h3333; mod_wrap = 1; step();
        RST = 1; gen_req = 1; gen_isel = 1; gen_msel = 1; mod_newI = 14'h2222; mod_wrap = 1;
        wr_en = 1; wr_grp = 2; wr_sel = 1; wr_data = 14'h0444; step(); idle();
        total++; if (addr_vld !== 1'b0 || addr_out !== 14'h0) begin bad++; $display("FAIL rst_mid_addr got=%h/%b exp=0000/0", addr_out, addr_vld); end
        total++; if (wrap_cnt !== 8'd0 || wrap_sticky !== 1'b0) begin bad++; $display("FAIL rst_mid_wrap got=%0d/%b exp=0/0", wrap_cnt, wrap_sticky); end
        gen_isel = 1; gen_msel = 1; #1;
        total++; if (mod_I !== 0 || mod_M !== 0 || mod_L !== 0) begin bad++; $display("FAIL rst_mid_regs got=%h/%h/%h exp=0", mod_I, mod_M, mod_L); end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            RST      = ($urandom_range(0, 59) == 0);
            gen_req  = 1'($urandom);
            gen_isel = 2'($urandom);
            gen_msel = 2'($urandom);
            brev     = 1'($urandom);
            mod_newI = 14'($urandom);
            mod_wrap = 1'($urandom);
            wr_en    = 1'($urandom);
            wr_grp   = 2'($urandom);
            wr_sel   = 2'($urandom);
            wr_data  = 14'($urandom);
            rd_en    = 1'($urandom);
            rd_grp   = 2'($urandom);
            rd_sel   = 2'($urandom);
            wrap_clr = ($urandom_range(0, 15) == 0);
            #1;
            total++;
            if (mod_I !== m_i[gen_isel] || mod_M !== m_m[gen_msel] || mod_L !== m_l[gen_isel]) begin
                bad++; $display("FAIL rnd_mod n=%0d got=%h/%h/%h exp=%h/%h/%h", n, mod_I, mod_M, mod_L, m_i[gen_isel], m_m[gen_msel], m_l[gen_isel]);
            end
            step();
            total++;
            if (addr_out !== e_addr || addr_vld !== e_vld) begin
                bad++; $display("FAIL rnd_addr n=%0d got=%h/%b exp=%h/%b", n, addr_out, addr_vld, e_addr, e_vld);
            end
            total++;
            if (rd_data !== e_rd || rd_vld !== e_rvld) begin
                bad++; $display("FAIL rnd_rd n=%0d got=%h/%b exp=%h/%b", n, rd_data, rd_vld, e_rd, e_rvld);
            end
            total++;
            if (wrap_sticky !== e_sticky || wrap_cnt !== 8'(e_cnt)) begin
                bad++; $display("FAIL rnd_wrap n=%0d got=%b/%0d exp=%b/%0d", n, wrap_sticky, wrap_cnt, e_sticky, e_cnt);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_modulo_wrap();
        test_linear();
        test_back_to_back();
        test_collision();
        test_brev();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dag_index_seq.md
Name: dag_index_seq

Overview:
- Index-register sequencer for one data address generator (DAG).
- Holds four sets of index (I), modifier (M) and length (L) registers.
- On each address request it presents the selected I/M/L to the downstream modulo-addressing unit, and issues the pre-modify I as the memory address (optionally bit-reversed).
- On the same edge it writes the modulo unit's new index back into I, and tracks wrap events.

Parameters:
- AW, 14, address/register width; fixed at 14 to match the modulo unit.
- BREV_EN, 1, 1 = bit-reverse path on addr_out implemented; 0 = brev input ignored.
- WCNT_W, 8, width of the saturating wrap counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- gen_req  in  1  address request this cycle.
- gen_isel  in  2  I/L register set used by the request.
- gen_msel  in  2  M register used by the request.
- brev  in  1  bit-reverse addr_out for this request.
- addr_out  out  AW  registered memory address.
- addr_vld  out  1  addr_out valid (one-cycle pulse per request).
- mod_I  out  AW  to modulo unit I input = I[gen_isel].
- mod_M  out  AW  to modulo unit M input = M[gen_msel].
- mod_L  out  AW  to modulo unit L input = L[gen_isel].
- mod_newI  in  AW  from modulo unit newI.
- mod_wrap  in  1  from modulo unit wrap.
- wr_en  in  1  register-file write.
- wr_grp  in  2  0 = I, 1 = M, 2 = L, 3 = reserved (write ignored).
- wr_sel  in  2  register index within group.
- wr_data  in  AW  write data.
- rd_en  in  1  register-file read.
- rd_grp  in  2  group, same encoding as wr_grp.
- rd_sel  in  2  register index within group.
- rd_data  out  AW  registered read data.
- rd_vld  out  1  rd_data valid pulse.
- wrap_clr  in  1  clear wrap_sticky and wrap_cnt.
- wrap_sticky  out  1  set by any wrap on a serviced request.
- wrap_cnt  out  WCNT_W  saturating count of wraps.

Behaviour:
- Reset (RST=1 at an edge): all I/M/L = 0; addr_out = 0; addr_vld = 0; rd_data = 0; rd_vld = 0; wrap_sticky = 0; wrap_cnt = 0. Reset overrides every other input on that edge, including a request in flight.
- mod_I/mod_M/mod_L are combinational from the register outputs and gen_isel/gen_msel, independent of gen_req. There is no bypass of same-cycle writes.
- Request, cycle N with gen_req=1, at the closing edge:
  - addr_out <= I[isel] (old value), bit-reversed (bit k -> bit AW-1-k) when brev=1 and BREV_EN=1.
  - addr_vld <= 1.
  - I[isel] <= mod_newI.
  - If mod_wrap=1: wrap_sticky <= 1 and wrap_cnt increments, saturating at all-ones.
- Request latency: address is valid 1 cycle after gen_req. Back-to-back requests are allowed every cycle; a request to the same isel in cycle N+1 sees the updated I.
- gen_req=0: addr_vld <= 0, addr_out holds, and mod_wrap is ignored.
- Write (wr_en=1, wr_grp != 3): the target register is updated at the edge.
- Write/post-modify collision (wr_grp=0, wr_sel = gen_isel, both active): the explicit write wins, and mod_newI is discarded. addr_out still uses the old I, and the wrap is still counted.
- A write to M or L in the same cycle as a request that uses that register: the request uses the old value.
- Read: rd_data <= selected register value before the edge (pre-write, pre-modify). rd_vld <= rd_en. rd_grp=3 returns 0 with rd_vld=1.
- wrap_clr with a simultaneous counted wrap: the set wins, giving wrap_sticky=1 and wrap_cnt=1.
- Arithmetic: all modulo/linear arithmetic is done by the downstream unit; this block only stores and steers data.
  - L=0 means linear addressing; M is two's complement AW bits.

Test Plan:
- Modulo wrap up: L0=10, I0=8, M0=3, request isel=0 msel=0 -> addr_out=8, addr_vld=1 next cycle, I0=1, wrap_sticky=1, wrap_cnt=1.
- Linear wrap: L1=0, I1=0x3FFE, M1=3, request -> addr_out=0x3FFE, I1=0x0001, wrap_cnt unchanged.
- Negative modifier: L2=10, I2=16, M2=0x3FFD (-3), two back-to-back requests -> addr_out 16 then 23, I2 ends 20, wrap_cnt +1.
- Collision: request isel=3 with I3=5, M=1, and same-cycle write I3=0x0100 -> addr_out=5, I3=0x0100. A same-cycle read of I3 returns 5.
- Bit reverse: I0=0x0001, M=0, L=0, brev=1 -> addr_out=0x2000, I0 unchanged.
- Reset mid-stream and saturation:
  - 300 wrapping requests -> wrap_cnt=255.
  - RST during a request -> all registers 0, addr_vld=0, no write-back.
  - wrap_clr alone -> sticky=0, cnt=0.
